// File: rtl/npu_pkg.sv
// Shared definitions for the NPU output-buffer path.
//   obuf_state_e    : tile-sequencing states of obuf_ctrl
//   OBUF_FIFO_DEPTH : entries in the drain-side output FIFO
package npu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } obuf_state_e;

  localparam int unsigned OBUF_FIFO_DEPTH = 2;

endpackage

// File: rtl/obuf_ctrl_if.sv
// Downstream row stream leaving the output buffer controller.
//   out_data  : one drained buffer row (all columns)
//   out_valid : out_data holds a row
//   out_ready : consumer accepts; a transfer happens when both are high
// master = obuf_ctrl side, slave = consumer side.
interface obuf_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/obuf_skid_fifo.sv
// Small circular FIFO with valid/ready on both sides, used to absorb
// downstream backpressure while buffer reads are in flight.
//   clk, reset           : clock, synchronous active-high reset (empties FIFO)
//   in_valid/in_ready    : write side handshake, in_data written on transfer
//   out_valid/out_ready  : read side handshake, out_data is the head entry
//   count                : current occupancy
// The head entry is held in storage until popped, so out_data is stable
// while out_valid is high and out_ready is low.
module obuf_skid_fifo
  import npu_pkg::*;
#(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = OBUF_FIFO_DEPTH,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = (cnt < CNT_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];
  assign count     = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/obuf_ctrl.sv
// Output buffer controller: sequences one output tile through the
// systolic-array output buffer.
//   WRITE  : enables the output address generator while the array
//            streams results in, then waits one settle cycle
//   DRAIN  : reads the tile rows back out of the buffer and sends them
//            downstream through a 2-entry FIFO with valid/ready
//   FINISH : one-cycle done pulse
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : tile start pulse (IDLE only)
//   cfg_num_rows/cols/base_addr : tile configuration, latched on start
//   ag_o_on           : output address generator enable
//   num_cols, base_addr : latched configuration driven to the buffer
//   read_addr, rd_data : buffer read port (data one cycle after address)
//   dn                : downstream row stream (out_data/out_valid/out_ready)
//   busy, done        : status
module obuf_ctrl
  import npu_pkg::*;
#(
  parameter  int unsigned RAM_SIZE   = 256,
  parameter  int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter  int unsigned ARRAY_M    = 8,
  parameter  int unsigned ACT_WIDTH  = 8,
  localparam int unsigned COL_W      = $clog2(ARRAY_M) + 1,
  localparam int unsigned DATA_W     = ACT_WIDTH * ARRAY_M
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   cfg_num_rows,
  input  logic [COL_W-1:0]      cfg_num_cols,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  output logic                  ag_o_on,
  output logic [COL_W-1:0]      num_cols,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_W-1:0]     rd_data,
  obuf_ctrl_if.master           dn,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned RCNT_W = ADDR_WIDTH + 1;
  localparam int unsigned WCNT_W = ADDR_WIDTH + COL_W + 1;
  localparam int unsigned FCNT_W = $clog2(OBUF_FIFO_DEPTH + 1);

  obuf_state_e         state;
  obuf_state_e         state_nxt;

  logic [RCNT_W-1:0]     num_rows_q;
  logic [RCNT_W-1:0]     rd_cnt;
  logic [RCNT_W-1:0]     xfer_cnt;
  logic [WCNT_W-1:0]     wr_cnt;
  logic [WCNT_W-1:0]     wr_len;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_pending;

  logic                  start_ok;
  logic                  issue;
  logic                  credit_ok;
  logic                  last_xfer;

  logic                  fifo_in_ready;
  logic                  fifo_push;
  logic                  fifo_out_valid;
  logic                  fifo_pop;
  logic [DATA_W-1:0]     fifo_out_data;
  logic [FCNT_W-1:0]     fifo_count;

  assign start_ok  = (state == ST_IDLE) && start;
  assign wr_len    = WCNT_W'(num_rows_q) + WCNT_W'(num_cols) - WCNT_W'(1);
  assign fifo_pop  = fifo_out_valid && dn.out_ready;
  assign fifo_push = rd_pending && fifo_in_ready;
  assign last_xfer = fifo_pop && (xfer_cnt == num_rows_q - RCNT_W'(1));

  // A read may issue when stored entries plus the read already in flight,
  // less the entry leaving this cycle, leave a free slot. Counting the pop
  // keeps one row per cycle with a 2-entry FIFO and one read in flight.
  assign credit_ok = ({1'b0, fifo_count} + {{FCNT_W{1'b0}}, rd_pending}) <
                     ({1'b0, FCNT_W'(OBUF_FIFO_DEPTH)} + {{FCNT_W{1'b0}}, fifo_pop});

  assign read_addr    = rd_ptr;
  assign dn.out_valid = fifo_out_valid;
  assign dn.out_data  = fifo_out_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = (cfg_num_rows == '0) ? ST_FINISH : ST_WRITE;
      end
      ST_WRITE: begin
        // wr_cnt == wr_len is the settle cycle with ag_o_on already low
        if (wr_cnt == wr_len) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_xfer) state_nxt = ST_FINISH;
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ag_o_on = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    issue   = 1'b0;
    unique case (state)
      ST_IDLE: ;
      ST_WRITE: begin
        busy    = 1'b1;
        ag_o_on = (wr_cnt < wr_len);
      end
      ST_DRAIN: begin
        busy  = 1'b1;
        issue = (rd_cnt != num_rows_q) && credit_ok;
      end
      ST_FINISH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Configuration latch, counters and read pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      num_rows_q <= '0;
      num_cols   <= '0;
      base_addr  <= '0;
      rd_ptr     <= '0;
      rd_cnt     <= '0;
      xfer_cnt   <= '0;
      wr_cnt     <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= issue;
      if (start_ok) begin
        num_rows_q <= cfg_num_rows;
        num_cols   <= cfg_num_cols;
        base_addr  <= cfg_base_addr;
        rd_ptr     <= cfg_base_addr;
        rd_cnt     <= '0;
        xfer_cnt   <= '0;
        wr_cnt     <= '0;
      end else begin
        if (state == ST_WRITE) wr_cnt <= wr_cnt + WCNT_W'(1);
        if (issue) begin
          rd_cnt <= rd_cnt + RCNT_W'(1);
          rd_ptr <= (rd_ptr == ADDR_WIDTH'(RAM_SIZE - 1)) ? '0 : rd_ptr + ADDR_WIDTH'(1);
        end
        if (fifo_pop) xfer_cnt <= xfer_cnt + RCNT_W'(1);
      end
    end
  end

  obuf_skid_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (OBUF_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (fifo_push),
    .in_ready  (fifo_in_ready),
    .in_data   (rd_data),
    .out_valid (fifo_out_valid),
    .out_ready (dn.out_ready),
    .out_data  (fifo_out_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_obuf_ctrl.sv
// Self-checking bench for obuf_ctrl: a behavioural buffer RAM answers
// read_addr one cycle later, expected rows are queued at tile start and
// compared as the downstream handshake completes.
module tb_obuf_ctrl;

  localparam int unsigned RAM_SIZE = 256;
  localparam int unsigned AW       = 8;
  localparam int unsigned ARRAY_M  = 8;
  localparam int unsigned ACT_W    = 8;
  localparam int unsigned COL_W    = 4;
  localparam int unsigned DW       = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   cfg_num_rows;
  logic [COL_W-1:0] cfg_num_cols;
  logic [AW-1:0] cfg_base_addr;
  logic          ag_o_on;
  logic [COL_W-1:0] num_cols;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;

  obuf_ctrl_if #(.DATA_WIDTH(DW)) dn ();

  obuf_ctrl #(
    .RAM_SIZE   (RAM_SIZE),
    .ADDR_WIDTH (AW),
    .ARRAY_M    (ARRAY_M),
    .ACT_WIDTH  (ACT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_num_rows  (cfg_num_rows),
    .cfg_num_cols  (cfg_num_cols),
    .cfg_base_addr (cfg_base_addr),
    .ag_o_on       (ag_o_on),
    .num_cols      (num_cols),
    .base_addr     (base_addr),
    .read_addr     (read_addr),
    .rd_data       (rd_data),
    .dn            (dn),
    .busy          (busy),
    .done          (done)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Buffer contents: unique per address so the data also proves the address.
  function automatic logic [63:0] mem_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hA5, a + 8'd7, ~a ^ 8'h33, a, 8'h3C};
  endfunction

  always @(posedge clk) rd_data <= mem_word(read_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  logic [63:0] sb [$];
  logic [63:0] exp_row;
  logic [63:0] prev_data = '0;
  bit          prev_stall = 1'b0;
  int ready_mode = 0;
  int ag_cnt = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0;
  int tile_xfers = 0, first_xfer_cyc = 0, last_xfer_cyc = 0, last_ag_cyc = 0;
  int tile_done0 = 0;

  always @(negedge clk) begin
    if (ag_o_on) begin
      ag_cnt++;
      last_ag_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_stall && !reset) begin
      check("stall_valid", 64'(dn.out_valid), 64'(1));
      check("stall_data", dn.out_data, prev_data);
    end
    if (dn.out_valid && dn.out_ready) begin
      if (sb.size() == 0) begin
        check("extra_row_qsize", 64'(sb.size()), 64'(1));
      end else begin
        exp_row = sb.pop_front();
        check("row_data", dn.out_data, exp_row);
      end
      if (ready_mode == 0 && tile_xfers > 0)
        check("back_to_back", 64'(cyc), 64'(last_xfer_cyc + 1));
      if (tile_xfers == 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      tile_xfers++;
    end
    prev_stall = dn.out_valid && !dn.out_ready;
    prev_data  = dn.out_data;
  end

  // Downstream ready: always high, or the 1,0,0 repeating pattern
  initial begin
    int rp;
    rp = 0;
    dn.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        dn.out_ready = 1'b1;
      end else begin
        dn.out_ready = ((rp % 3) == 0);
        rp++;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_ag_o_on", 64'(ag_o_on), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_out_valid", 64'(dn.out_valid), 64'(0));
    check("rst_read_addr", 64'(read_addr), 64'(0));
    check("rst_num_cols", 64'(num_cols), 64'(0));
    check("rst_base_addr", 64'(base_addr), 64'(0));
  endtask

  task automatic start_tile(input int rows, input int cols, input int base);
    for (int k = 0; k < rows; k++) sb.push_back(mem_word(8'((base + k) % RAM_SIZE)));
    ag_cnt     = 0;
    busy_cnt   = 0;
    tile_xfers = 0;
    tile_done0 = done_cnt;
    @(negedge clk); #2;
    cfg_num_rows  = 9'(rows);
    cfg_num_cols  = 4'(cols);
    cfg_base_addr = 8'(base);
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    // Scramble the configuration: the latched copy must be used from now on
    cfg_num_rows  = 9'($urandom_range(1, 256));
    cfg_num_cols  = 4'($urandom_range(1, 8));
    cfg_base_addr = 8'($urandom);
  endtask

  task automatic finish_tile(input int rows, input int cols, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != tile_done0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk); #2;
    end
    check("done_seen", 64'(seen), 64'(1));
    @(negedge clk); #2;
    check("done_pulse_width", 64'(done), 64'(0));
    check("idle_after_done", 64'(busy), 64'(0));
    check("done_count", 64'(done_cnt - tile_done0), 64'(1));
    check("ag_cycles", 64'(ag_cnt), 64'((rows > 0) ? (rows + cols - 1) : 0));
    check("row_count", 64'(tile_xfers), 64'(rows));
    check("sb_empty", 64'(sb.size()), 64'(0));
    if (rows > 0)
      check("done_after_last", 64'(done_cyc), 64'(last_xfer_cyc + 1));
    if (rows > 0 && ready_mode == 0)
      check("first_row_latency", 64'(first_xfer_cyc), 64'(last_ag_cyc + 4));
  endtask

  initial begin
    int d0;
    reset         = 1'b1;
    start         = 1'b0;
    cfg_num_rows  = '0;
    cfg_num_cols  = '0;
    cfg_base_addr = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    #2;
    reset = 1'b0;

    // Basic tile
    start_tile(4, 8, 'h10);
    check("num_cols_latched", 64'(num_cols), 64'(8));
    check("base_addr_latched", 64'(base_addr), 64'('h10));
    finish_tile(4, 8, 200);

    // Address wrap at RAM_SIZE
    start_tile(3, 8, 'hFE);
    finish_tile(3, 8, 200);

    // Backpressure
    ready_mode = 1;
    start_tile(6, 8, 'h30);
    finish_tile(6, 8, 400);
    ready_mode = 0;

    // Empty tile
    start_tile(0, 8, 'h55);
    finish_tile(0, 8, 20);
    check("zero_busy_cycles", 64'(busy_cnt), 64'(1));

    // Reset in mid-drain
    start_tile(8, 8, 'h40);
    for (int i = 0; i < 200; i++) begin
      if (tile_xfers >= 2) break;
      @(negedge clk); #2;
    end
    check("mid_drain_xfers", 64'(tile_xfers), 64'(2));
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk); #2;
    check_reset_outputs();
    sb.delete();
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    check("abort_no_valid", 64'(dn.out_valid), 64'(0));
    start_tile(8, 8, 'h40);
    finish_tile(8, 8, 200);

    // Start pulse during WRITE with other settings is ignored
    start_tile(5, 4, 'h20);
    repeat (2) @(negedge clk);
    #2;
    cfg_num_rows  = 9'(2);
    cfg_num_cols  = 4'(8);
    cfg_base_addr = 8'h80;
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    check("num_cols_kept", 64'(num_cols), 64'(4));
    check("base_addr_kept", 64'(base_addr), 64'('h20));
    finish_tile(5, 4, 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
